spike_dispatcher: RTL and testbench

SPIKE_DISPATCHER -- requirements
Module: spike_dispatcher

---
 rtl/spike_dispatcher.sv | 137 +++++++++++++
 tb/tb_spike_dispatcher.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/spike_dispatcher.sv
// Spike dispatcher: walks a presynaptic spike frame lowest-index first,
// fetching one weight per set bit and handing it to the accumulator.
module spike_dispatcher #(
  parameter int N     = 256,
  parameter int WIDTH = 32,
  localparam int IDX_W = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N-1:0]            spike_vec,
  input  logic                    spike_valid,
  output logic                    spike_ready,
  output logic                    mem_rd_en,
  output logic [IDX_W-1:0]        mem_rd_addr,
  input  logic signed [WIDTH-1:0] mem_rd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDX_W-1:0]        out_idx,
  output logic signed [WIDTH-1:0] out_weight,
  output logic                    out_last,
  output logic                    frame_done,
  output logic [IDX_W:0]          spike_count
);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    FETCH,
    SEND,
    DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [N-1:0]            mask_q, mask_d;
  logic [IDX_W:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]        addr_q, addr_d;
  logic [IDX_W-1:0]        oidx_q, oidx_d;
  logic signed [WIDTH-1:0] wgt_q, wgt_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic [IDX_W-1:0]        low_idx;

  // Priority encoder: lowest set bit of the remaining mask
  always_comb begin
    low_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask_q[i]) low_idx = IDX_W'(i);
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    oidx_d      = oidx_q;
    wgt_d       = wgt_q;
    valid_d     = valid_q;
    last_d      = last_q;
    spike_ready = 1'b0;
    mem_rd_en   = 1'b0;
    mem_rd_addr = addr_q;
    frame_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        spike_ready = 1'b1;
        if (spike_valid) begin
          mask_d  = spike_vec;
          cnt_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (mask_q == '0) begin
          state_d = DONE;
        end else begin
          mem_rd_en       = 1'b1;
          mem_rd_addr     = low_idx;
          addr_d          = low_idx;
          mask_d[low_idx] = 1'b0;
          state_d         = FETCH;
        end
      end
      FETCH: begin
        wgt_d   = mem_rd_data;
        oidx_d  = addr_q;
        valid_d = 1'b1;
        last_d  = (mask_q == '0);
        state_d = SEND;
      end
      SEND: begin
        if (out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          cnt_d   = cnt_q + 1'b1;
          state_d = SCAN;
        end
      end
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      oidx_q  <= '0;
      wgt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      oidx_q  <= oidx_d;
      wgt_q   <= wgt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_last    = last_q;
  assign out_idx     = oidx_q;
  assign out_weight  = wgt_q;
  assign spike_count = cnt_q;

endmodule

// File: tb/tb_spike_dispatcher.sv
// Bench for spike_dispatcher: table vectors, hand sequences for
// reset/backpressure, and random frames against a queue model.
module tb_spike_dispatcher;

  localparam int N  = 8;
  localparam int W  = 32;
  localparam int IW = 3;

  logic                clk = 1'b0;
  logic                reset;
  logic [N-1:0]        spike_vec;
  logic                spike_valid;
  logic                spike_ready;
  logic                mem_rd_en;
  logic [IW-1:0]       mem_rd_addr;
  logic signed [W-1:0] mem_rd_data;
  logic                out_valid;
  logic                out_ready;
  logic [IW-1:0]       out_idx;
  logic signed [W-1:0] out_weight;
  logic                out_last;
  logic                frame_done;
  logic [IW:0]         spike_count;

  spike_dispatcher #(.N(N), .WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .spike_vec   (spike_vec),
    .spike_valid (spike_valid),
    .spike_ready (spike_ready),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_idx     (out_idx),
    .out_weight  (out_weight),
    .out_last    (out_last),
    .frame_done  (frame_done),
    .spike_count (spike_count)
  );

  always #5 clk = ~clk;

  logic signed [W-1:0] mem [N];

  initial mem_rd_data = '0;
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  int vecs = 0;
  int errs = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_mem(input bit neg3);
    for (int i = 0; i < N; i++) mem[i] = 10 * i;
    if (neg3) mem[3] = 32'hFFFF_FFFB;
  endtask

  // mode 0: out_ready always 1; 1: random; 2: stall first term 5 cycles
  task automatic run_frame(input logic [N-1:0] vec, input int mode,
                           input int exp_cnt);
    int                  q_idx[$];
    logic signed [W-1:0] q_w[$];
    int cyc, rd, stall;
    bit done;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        q_idx.push_back(i);
        q_w.push_back(mem[i]);
      end
    end
    @(negedge clk);
    check("spike_ready_idle", spike_ready, 1);
    spike_vec   = vec;
    spike_valid = 1'b1;
    @(posedge clk);
    #1;
    spike_valid = 1'b0;
    spike_vec   = N'($urandom);
    cyc   = 0;
    rd    = 0;
    stall = 0;
    done  = 0;
    while (!done && cyc < 600) begin
      @(negedge clk);
      if (frame_done) begin
        done = 1;
      end else begin
        case (mode)
          0:       out_ready = 1'b1;
          1:       out_ready = 1'($urandom % 2);
          default: out_ready = (stall >= 5);
        endcase
        if (mem_rd_en) begin
          rd++;
          check("rd_while_valid", out_valid, 0);
        end
        if (out_valid) begin
          if (q_idx.size() == 0) begin
            check("extra_term", 1, 0);
          end else begin
            check("out_idx", out_idx, q_idx[0]);
            check("out_weight", out_weight, q_w[0]);
            check("out_last", out_last, q_idx.size() == 1);
            if (!out_ready) stall++;
            if (out_ready) begin
              void'(q_idx.pop_front());
              void'(q_w.pop_front());
            end
          end
        end
        cyc++;
      end
    end
    check("frame_done_seen", done, 1);
    check("terms_left", q_idx.size(), 0);
    check("spike_count", spike_count, exp_cnt);
    check("rd_count", rd, exp_cnt);
    if (mode == 0) check("latency", cyc, 3 * exp_cnt + 1);
    @(negedge clk);
    check("done_one_cycle", frame_done, 0);
    check("ready_after", spike_ready, 1);
  endtask

  typedef struct {
    logic [N-1:0] vec;
    bit           neg3;
    int           mode;
    int           exp_cnt;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{8'b1010_0100, 1'b0, 0, 3};
    tbl[1] = '{8'b0000_0000, 1'b0, 0, 0};
    tbl[2] = '{8'b1111_1111, 1'b0, 0, 8};
    tbl[3] = '{8'b0000_0011, 1'b0, 2, 2};
    tbl[4] = '{8'b0000_1000, 1'b1, 0, 1};
    tbl[5] = '{8'b1111_1111, 1'b1, 1, 8};

    reset       = 1'b0;
    spike_vec   = '0;
    spike_valid = 1'b0;
    out_ready   = 1'b0;
    load_mem(0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_mem_rd_en", mem_rd_en, 0);
    check("rst_mem_rd_addr", mem_rd_addr, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_weight", out_weight, 0);
    check("rst_spike_count", spike_count, 0);
    check("rst_spike_ready", spike_ready, 1);
    reset = 1'b1;

    for (int t = 0; t < 6; t++) begin
      load_mem(tbl[t].neg3);
      run_frame(tbl[t].vec, tbl[t].mode, tbl[t].exp_cnt);
    end

    // Explicit bit pattern of -5 on the selected weight
    load_mem(1);
    @(negedge clk);
    spike_vec   = 8'b0000_1000;
    spike_valid = 1'b1;
    out_ready   = 1'b0;
    @(posedge clk);
    #1 spike_valid = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
    check("neg_valid", out_valid, 1);
    check("neg_bits", out_weight, 64'hFFFF_FFFF_FFFF_FFFB);
    check("neg_low32", out_weight[W-1:0], 32'hFFFF_FFFB);

    // Reset while a term waits in SEND
    #2 reset = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_frame_done", frame_done, 0);
    check("midrst_count", spike_count, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 check("midrst_ready", spike_ready, 1);
    check("midrst_no_done", frame_done, 0);
    load_mem(0);
    run_frame(8'b1000_0000, 0, 1);

    for (int r = 0; r < 25; r++) begin
      logic [N-1:0] v;
      v = N'($urandom);
      for (int i = 0; i < N; i++) mem[i] = $urandom;
      run_frame(v, 1, $countones(v));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
